// File: rtl/bram_dbg_bridge_pkg.sv
// Shared constants and state encoding for the block-RAM debug bridge.
// The bridge turns a host byte stream into port-B accesses on the CPU RAM.
package bram_dbg_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
    localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
    localparam logic [7:0] RSP_ACK = 8'h2B;  // '+'
    localparam logic [7:0] RSP_ERR = 8'h3F;  // '?'

    typedef enum logic [3:0] {
        IDLE,
        GET_AH,
        GET_AL,
        GET_N,
        WR_DATA,
        RD_REQ,
        RD_WAIT,
        RD_SEND,
        ACK,
        ERR
    } state_t;

    // States in which a command byte may be consumed.
    function automatic logic state_takes_cmd(state_t s);
        return (s == IDLE) || (s == GET_AH) || (s == GET_AL) ||
               (s == GET_N) || (s == WR_DATA);
    endfunction

endpackage

// File: rtl/bram_dbg_bridge_if.sv
// Command/response byte streams plus RAM port B, bundled for the bridge.
// master = the bridge side, slave = host pipe + RAM side.
interface bram_dbg_bridge_if #(
    parameter int DATA = 8,
    parameter int ADDR = 15
) ();
    logic [7:0]      cmd_data;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      rsp_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            b_en;
    logic            b_wr;
    logic [ADDR-1:0] b_addr;
    logic [DATA-1:0] b_din;
    logic [DATA-1:0] b_dout;

    modport master (
        input  cmd_data, cmd_valid, rsp_ready, b_dout,
        output cmd_ready, rsp_data, rsp_valid, b_en, b_wr, b_addr, b_din
    );

    modport slave (
        output cmd_data, cmd_valid, rsp_ready, b_dout,
        input  cmd_ready, rsp_data, rsp_valid, b_en, b_wr, b_addr, b_din
    );
endinterface

// File: rtl/bram_dbg_bridge.sv
// Byte-stream command engine mastering RAM port B: 'W' loads an image,
// 'R' dumps one back, anything else is answered with '?'.
module bram_dbg_bridge
    import bram_dbg_pkg::*;
#(
    parameter int DATA   = 8,
    parameter int ADDR   = 15,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    bram_dbg_bridge_if.master  bus,
    output logic               busy
);

    state_t          state, state_n;
    logic            is_wr, is_wr_n;
    logic [7:0]      ah, ah_n;
    logic [ADDR-1:0] addr, addr_n;
    logic [7:0]      cnt, cnt_n;
    logic [7:0]      wait_cnt, wait_n;
    logic            b_en_q, b_en_n;
    logic            b_wr_q, b_wr_n;
    logic [ADDR-1:0] b_addr_q, b_addr_n;
    logic [DATA-1:0] b_din_q, b_din_n;
    logic            rsp_valid_q, rsp_valid_n;
    logic [DATA-1:0] rsp_data_q, rsp_data_n;
    logic            cmd_rdy, cmd_fire, rsp_fire;

    // Ready depends on state only; held low while reset is applied.
    assign cmd_rdy  = state_takes_cmd(state) && !reset;
    assign cmd_fire = cmd_rdy && bus.cmd_valid;
    assign rsp_fire = rsp_valid_q && bus.rsp_ready;

    assign bus.cmd_ready = cmd_rdy;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.b_en      = b_en_q;
    assign bus.b_wr      = b_wr_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.b_din     = b_din_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            is_wr       <= 1'b0;
            ah          <= '0;
            addr        <= '0;
            cnt         <= '0;
            wait_cnt    <= '0;
            b_en_q      <= 1'b0;
            b_wr_q      <= 1'b0;
            b_addr_q    <= '0;
            b_din_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state       <= state_n;
            is_wr       <= is_wr_n;
            ah          <= ah_n;
            addr        <= addr_n;
            cnt         <= cnt_n;
            wait_cnt    <= wait_n;
            b_en_q      <= b_en_n;
            b_wr_q      <= b_wr_n;
            b_addr_q    <= b_addr_n;
            b_din_q     <= b_din_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_data_q  <= rsp_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        is_wr_n     = is_wr;
        ah_n        = ah;
        addr_n      = addr;
        cnt_n       = cnt;
        wait_n      = wait_cnt;
        b_en_n      = 1'b0;
        b_wr_n      = 1'b0;
        b_addr_n    = b_addr_q;
        b_din_n     = b_din_q;
        rsp_valid_n = rsp_valid_q;
        rsp_data_n  = rsp_data_q;

        case (state)
            IDLE: if (cmd_fire) begin
                if (bus.cmd_data == OP_WR || bus.cmd_data == OP_RD) begin
                    is_wr_n = (bus.cmd_data == OP_WR);
                    state_n = GET_AH;
                end else begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = RSP_ERR;
                    state_n     = ERR;
                end
            end
            GET_AH: if (cmd_fire) begin
                ah_n    = bus.cmd_data;
                state_n = GET_AL;
            end
            GET_AL: if (cmd_fire) begin
                addr_n  = ADDR'({ah, bus.cmd_data});
                state_n = GET_N;
            end
            GET_N: if (cmd_fire) begin
                cnt_n = bus.cmd_data;
                if (is_wr) begin
                    state_n = WR_DATA;
                end else begin
                    b_en_n   = 1'b1;
                    b_addr_n = addr;
                    state_n  = RD_REQ;
                end
            end
            WR_DATA: if (cmd_fire) begin
                b_en_n   = 1'b1;
                b_wr_n   = 1'b1;
                b_addr_n = addr;
                b_din_n  = bus.cmd_data;
                addr_n   = addr + ADDR'(1);
                if (cnt == 8'd0) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = RSP_ACK;
                    state_n     = ACK;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            RD_REQ: begin
                wait_n  = 8'(RD_LAT - 1);
                state_n = RD_WAIT;
            end
            // Wait out the remaining read latency, then grab b_dout.
            RD_WAIT: begin
                if (wait_cnt == 8'd0) begin
                    rsp_data_n  = bus.b_dout;
                    rsp_valid_n = 1'b1;
                    state_n     = RD_SEND;
                end else begin
                    wait_n = wait_cnt - 8'd1;
                end
            end
            RD_SEND: if (rsp_fire) begin
                rsp_valid_n = 1'b0;
                if (cnt == 8'd0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n    = cnt - 8'd1;
                    addr_n   = addr + ADDR'(1);
                    b_en_n   = 1'b1;
                    b_addr_n = addr + ADDR'(1);
                    state_n  = RD_REQ;
                end
            end
            ACK, ERR: if (rsp_fire) begin
                rsp_valid_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/bram_dbg_bridge.md
Name: bram_dbg_bridge

Overview:
- Byte-stream command engine that masters port B of the CPU dual-port block RAM while the 6809 owns port A.
- Lets a host, via a UART byte pipe, load images into CPU RAM and dump them back, with no CPU involvement.
- Consumes command bytes on a valid/ready input stream, drives b_en/b_wr/b_addr/b_din, and returns ack or read-data bytes on a valid/ready output stream.

Parameters:
- DATA, 8, RAM data width; the byte protocol requires 8.
- ADDR, 15, RAM address width; supported range 9..16.
- RD_LAT, 1, port-B read latency in clocks from the b_en/address cycle to valid b_dout.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_data  input  8  command/argument/data byte.
- cmd_valid  input  1  cmd_data is valid.
- cmd_ready  output  1  bridge accepts cmd_data this cycle.
- rsp_data  output  8  response byte.
- rsp_valid  output  1  rsp_data is valid.
- rsp_ready  input  1  consumer accepts rsp_data this cycle.
- b_en  output  1  RAM port B enable.
- b_wr  output  1  RAM port B write strobe.
- b_addr  output  ADDR  RAM port B address.
- b_din  output  DATA  RAM port B write data.
- b_dout  input  DATA  RAM port B read data.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Handshakes:
  - A byte transfers on a cycle where valid and ready are both high.
  - rsp_valid/rsp_data stay stable until accepted.
  - cmd_ready is combinational from state only, never from cmd_valid.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, b_en=0, b_wr=0, b_addr=0, b_din=0, busy=0, state=IDLE. cmd_ready rises in the first cycle after reset deasserts.
- Protocol (all multi-byte fields big-endian):
  - Write: 0x57 'W', AH, AL, N, then N+1 data bytes, then response 0x2B '+'.
  - Read: 0x52 'R', AH, AL, N, then N+1 response bytes from addr, addr+1, ...
  - Any other opcode in IDLE: response 0x3F '?', return to IDLE, no RAM access.
- Address handling:
  - Address = {AH,AL}[ADDR-1:0]; upper bits are ignored.
  - The address increments modulo 2^ADDR, so 0x7FFF wraps to 0x0000 at ADDR=15.
  - The 8-bit down-counter N gives 1..256 bytes; N=0xFF transfers 256.
- States: IDLE, GET_AH, GET_AL, GET_N, WR_DATA, RD_REQ, RD_WAIT, RD_SEND, ACK, ERR.
  - cmd_ready=1 only in IDLE, GET_AH, GET_AL, GET_N and WR_DATA.
- Transitions:
  - IDLE to GET_AH on opcode 'W' or 'R' (opcode latched); to ERR otherwise.
  - GET_AH to GET_AL to GET_N, one accepted byte each.
  - GET_N to WR_DATA if the opcode is 'W', else RD_REQ.
- WR_DATA:
  - On each accepted byte: b_en=b_wr=1 for exactly that cycle, with b_din=byte and b_addr=current address.
  - Then the address increments.
  - On the last byte (count==0), go to ACK.
- Read path:
  - RD_REQ: b_en=1, b_wr=0 for one cycle.
  - RD_WAIT: RD_LAT-1 extra cycles (0 when RD_LAT=1).
  - Capture b_dout into rsp_data on the cycle it is valid.
  - RD_SEND: rsp_valid=1. On acceptance, if count==0 go to IDLE; else decrement count, increment address, go to RD_REQ.
  - Read issue-to-response latency is RD_LAT+1 clocks per byte. No prefetch is required.
- ACK and ERR: present 0x2B or 0x3F with rsp_valid=1; go to IDLE on acceptance.
- Port B outputs:
  - b_en/b_wr are registered single-cycle pulses.
  - b_en=0 whenever no access is issued; b_wr is never high without b_en.
- Boundary conditions:
  - rsp_ready held low: stall indefinitely in RD_SEND/ACK/ERR, no extra RAM reads.
  - cmd_valid gaps between bytes: wait indefinitely; there is no timeout.
  - reset mid-transfer: everything returns to reset values; a partially written image stays in RAM.
  - Port A collisions are not arbitrated by this block; the CPU is held in reset during loads by system convention.

Decomposition:
- Shared package bram_dbg_pkg:
  - Opcode constants OP_WR=8'h57, OP_RD=8'h52.
  - Response constants RSP_ACK=8'h2B, RSP_ERR=8'h3F.
  - State enumeration localparams.
- Single module; no sub-module needed.
- A behavioural bram model with RD_LAT registered read is required only in the bench.

Test Plan:
- After reset, drive 57 00 10 02 AA BB CC: expect writes 0x0010=AA, 0x0011=BB, 0x0012=CC, then rsp 0x2B; b_wr pulses exactly 3 times.
- Then drive 52 00 10 02: expect rsp bytes AA, BB, CC in order, then busy=0.
- Wrap: write 57 FF FF 01 11 22 → RAM 0x7FFF=11, 0x0000=22 (AH bit7 ignored); read 52 7F FF 01 returns 11, 22.
- Opcode 0x41: expect single rsp 0x3F, no b_en pulse, and cmd_ready back high within 2 cycles of acceptance.
- Backpressure: read 52 00 00 FF with rsp_ready toggled randomly: exactly 256 bytes out, data matches RAM, exactly 256 b_en pulses.
- Assert reset during WR_DATA after 2 of 4 bytes: outputs return to zero at once, and a subsequent 'R' command works normally.
